soc_system_pio_edge: RTL and testbench

Parametrised Avalon-MM parallel I/O port. It adds the following beyond a single-bit PIO:
- configurable width
- input synchronisers
- per-bit output enable
- edge capture with write-1-to-clear
- masked level interrupt derived from captured edges

It sits on the lightweight HPS-to-FPGA bus alongside the other soc_system peripherals and drives one IRQ line to the HPS.

---
 rtl/soc_system_pio_edge.sv | 120 ++++++++++++
 tb/tb_soc_system_pio_edge.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_edge.sv
// Avalon-MM parallel I/O port with input synchronisers, per-bit direction, edge capture
// (write-1-to-clear) and a masked level interrupt. Read data is registered (latency 1).
module soc_system_pio_edge #(
  parameter int          WIDTH       = 8,
  parameter int          EDGE_MODE   = 0,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdat;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  assign unused_ok = ^{read_n, writedata};

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign wr_en   = chipselect & ~write_n;
  assign wdat    = writedata[WIDTH-1:0];
  assign armed   = (arm_cnt == 3'(ARM_CYCLES));
  assign rise    = in_sync & ~prev;
  assign fall    = ~in_sync & prev;
  assign clr     = (wr_en && address == 2'd3) ? wdat : '0;

  always_comb begin
    sel = rise;
    case (EDGE_MODE)
      1:       sel = fall;
      2:       sel = rise | fall;
      default: sel = rise;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= in_sync;
    end
  end

  // Capture is held off until the synchroniser and prev have flushed out reset zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clr) | (armed ? sel : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= OUT_RESET[WIDTH-1:0];
      out_oe   <= '0;
      irq_mask <= '0;
    end else if (wr_en) begin
      case (address)
        2'd0:    out_port <= wdat;
        2'd1:    out_oe   <= wdat;
        2'd2:    irq_mask <= wdat;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = in_sync;
      2'd1:    rd_mux[WIDTH-1:0] = out_oe;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      default: rd_mux[WIDTH-1:0] = edge_capture;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_soc_system_pio_edge.sv
// Bench for soc_system_pio_edge: a rising-edge instance and an any-edge instance on one bus.
module tb_soc_system_pio_edge;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        cs1, cs2;
  logic        write_n, read_n;
  logic [31:0] writedata;
  logic [31:0] readdata1, readdata2;
  logic [7:0]  in_port1, in_port2;
  logic [7:0]  out_port1, out_port2, out_oe1, out_oe2;
  logic        irq1, irq2;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  soc_system_pio_edge #(.WIDTH(8), .EDGE_MODE(0), .SYNC_STAGES(2), .OUT_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs1), .write_n(write_n),
    .read_n(read_n), .writedata(writedata), .readdata(readdata1), .in_port(in_port1),
    .out_port(out_port1), .out_oe(out_oe1), .irq(irq1));

  soc_system_pio_edge #(.WIDTH(8), .EDGE_MODE(2), .SYNC_STAGES(2), .OUT_RESET(32'hA5)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs2), .write_n(write_n),
    .read_n(read_n), .writedata(writedata), .readdata(readdata2), .in_port(in_port2),
    .out_port(out_port2), .out_oe(out_oe2), .irq(irq2));

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int which, input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0;
    cs1 = (which == 1); cs2 = (which == 2);
    tick();
    write_n = 1'b1; cs1 = 1'b0; cs2 = 1'b0;
  endtask

  // Expected value queued at issue, popped when registered readdata is valid.
  task automatic rd(input int which, input logic [1:0] a, input logic [31:0] e, input string name);
    logic [31:0] got, want;
    address = a; read_n = 1'b0;
    cs1 = (which == 1); cs2 = (which == 2);
    exp_q.push_back(e);
    tick();
    got = (which == 1) ? readdata1 : readdata2;
    want = exp_q.pop_front();
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: readdata=%h expected %h", name, got, want);
    end
    read_n = 1'b1; cs1 = 1'b0; cs2 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_port1 = 8'hFF; in_port2 = 8'hFF;
    tick(3);
    tests++;
    if ({out_port1, out_oe1, irq1, readdata1} !== {8'h00, 8'h00, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_dut1: out=%h oe=%h irq=%b rd=%h expected 00 00 0 0", out_port1, out_oe1, irq1, readdata1);
    end
    tests++;
    if ({out_port2, out_oe2, irq2, readdata2} !== {8'hA5, 8'h00, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_dut2: out=%h oe=%h irq=%b rd=%h expected A5 00 0 0", out_port2, out_oe2, irq2, readdata2);
    end
    reset = 1'b0;
    tick(10);
    rd(1, 2'd3, 32'h0, "arm_cap1");
    rd(2, 2'd3, 32'h0, "arm_cap2");
    rd(1, 2'd0, 32'h000000FF, "data_in");
  endtask

  task automatic test_rising;
    wr(1, 2'd2, 32'h04);
    in_port1 = 8'hFB;
    tick(4);
    rd(1, 2'd3, 32'h0, "fall_ignored");
    in_port1 = 8'hFF;
    tick(2);
    tests++;
    if (irq1 !== 1'b0) begin fails++; $display("FAIL irq_early: irq=%b expected 0", irq1); end
    tick();
    tests++;
    if (irq1 !== 1'b1) begin fails++; $display("FAIL irq_rise: irq=%b expected 1", irq1); end
    rd(1, 2'd3, 32'h04, "cap_rise");
    in_port1 = 8'hFB;
    tick(4);
    rd(1, 2'd3, 32'h04, "cap_hold_fall");
  endtask

  task automatic test_set_wins;
    in_port1 = 8'hFF;
    tick(2);
    wr(1, 2'd3, 32'h04);
    tests++;
    if (irq1 !== 1'b1) begin fails++; $display("FAIL set_wins_irq: irq=%b expected 1", irq1); end
    rd(1, 2'd3, 32'h04, "set_wins_cap");
    wr(1, 2'd3, 32'h04);
    tests++;
    if (irq1 !== 1'b0) begin fails++; $display("FAIL clear_irq: irq=%b expected 0", irq1); end
    rd(1, 2'd3, 32'h0, "clear_cap");
  endtask

  task automatic test_any_edge;
    in_port2 = 8'hFE;
    tick(4);
    rd(2, 2'd3, 32'h01, "any_first");
    tests++;
    if (irq2 !== 1'b0) begin fails++; $display("FAIL masked_irq: irq=%b expected 0", irq2); end
    wr(2, 2'd3, 32'h01);
    rd(2, 2'd3, 32'h0, "any_cleared");
    in_port2 = 8'hFF;
    tick(4);
    rd(2, 2'd3, 32'h01, "any_second");
    tests++;
    if (irq2 !== 1'b0) begin fails++; $display("FAIL masked_irq2: irq=%b expected 0", irq2); end
  endtask

  task automatic test_out_dir;
    wr(1, 2'd0, 32'hDEADBEEF);
    tests++;
    if (out_port1 !== 8'hEF) begin fails++; $display("FAIL out_port: got %h expected EF", out_port1); end
    wr(1, 2'd1, 32'h0F);
    tests++;
    if (out_oe1 !== 8'h0F) begin fails++; $display("FAIL out_oe: got %h expected 0F", out_oe1); end
    rd(1, 2'd1, 32'h0000000F, "dir_read");
    rd(1, 2'd2, 32'h00000004, "mask_read");
    rd(1, 2'd0, 32'h000000FF, "data_vs_dir");
  endtask

  task automatic test_mid_reset;
    in_port1 = 8'h00;
    tick(4);
    in_port1 = 8'hFF;
    tick(4);
    rd(1, 2'd3, 32'h000000FF, "cap_all");
    tests++;
    if (irq1 !== 1'b1) begin fails++; $display("FAIL irq_all: irq=%b expected 1", irq1); end
    reset = 1'b1;
    tick();
    tests++;
    if ({out_port1, out_oe1, irq1, readdata1} !== {8'h00, 8'h00, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL mid_reset: out=%h oe=%h irq=%b rd=%h expected 00 00 0 0", out_port1, out_oe1, irq1, readdata1);
    end
    tick();
    reset = 1'b0;
    tick(10);
    rd(1, 2'd3, 32'h0, "rearm_cap");
    rd(1, 2'd2, 32'h0, "rearm_mask");
    tests++;
    if (irq1 !== 1'b0) begin fails++; $display("FAIL rearm_irq: irq=%b expected 0", irq1); end
  endtask

  initial begin
    reset = 1'b1; address = '0; cs1 = 1'b0; cs2 = 1'b0;
    write_n = 1'b1; read_n = 1'b1; writedata = '0;
    in_port1 = '0; in_port2 = '0;
    test_reset();
    test_rising();
    test_set_wins();
    test_any_edge();
    test_out_dir();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
